uart_cfg: RTL and testbench

- Parametrised full-duplex UART, next generation of the fixed 8N1 serial block.
- Adds generic data width, runtime baud divisor, runtime parity (none/even/odd), 1 or 2 stop bits, an input synchroniser, a valid/ready transmit handshake, and per-byte error flags.
- Sits between the CPU's memory-mapped I/O logic and the board serial pins.

---
 rtl/uart_cfg.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// Configurable full-duplex UART: runtime baud divisor, parity and stop bits,
// valid/ready transmit handshake and per-frame receive error flags.
module uart_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    logic par_en_in;
    assign par_en_in = (parity_mode == 2'd1) || (parity_mode == 2'd2);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [DIV_W-1:0]     tx_div_q, tx_div_d;
    logic [DIV_W-1:0]     tx_baud_q, tx_baud_d;
    logic [OS_W-1:0]      tx_os_q, tx_os_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_par_en_q, tx_par_en_d;
    logic                 tx_two_stop_q, tx_two_stop_d;
    logic                 tx_stop_q, tx_stop_d;
    logic                 tx_q, tx_d;
    logic                 tx_tick, tx_bit_done;

    assign tx_tick     = (tx_div_q == '0);
    assign tx_bit_done = tx_tick && (tx_os_q == OS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            tx_div_q      <= '0;
            tx_baud_q     <= '0;
            tx_os_q       <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_par_en_q   <= 1'b0;
            tx_two_stop_q <= 1'b0;
            tx_stop_q     <= 1'b0;
            tx_q          <= 1'b1;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_div_q      <= tx_div_d;
            tx_baud_q     <= tx_baud_d;
            tx_os_q       <= tx_os_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_two_stop_q <= tx_two_stop_d;
            tx_stop_q     <= tx_stop_d;
            tx_q          <= tx_d;
        end
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_div_d      = tx_div_q;
        tx_baud_d     = tx_baud_q;
        tx_os_d       = tx_os_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        tx_par_d      = tx_par_q;
        tx_par_en_d   = tx_par_en_q;
        tx_two_stop_d = tx_two_stop_q;
        tx_stop_d     = tx_stop_q;
        tx_d          = 1'b1;

        if (tx_state_q != TX_IDLE) begin
            if (tx_tick) begin
                tx_div_d = tx_baud_q;
                tx_os_d  = tx_bit_done ? '0 : tx_os_q + 1'b1;
            end else begin
                tx_div_d = tx_div_q - 1'b1;
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d    = TX_START;
                    tx_shift_d    = tx_data;
                    tx_par_d      = (^tx_data) ^ (parity_mode == 2'd2);
                    tx_par_en_d   = par_en_in;
                    tx_two_stop_d = two_stop;
                    tx_baud_d     = baud_div;
                    tx_div_d      = baud_div;
                    tx_os_d       = '0;
                    tx_bit_d      = '0;
                    tx_stop_d     = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_done) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_done) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_done) begin
                    if (tx_two_stop_q && !tx_stop_q) tx_stop_d  = 1'b1;
                    else                             tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = (tx_state_q == TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_t            rx_state_q, rx_state_d;
    logic [DIV_W-1:0]     rx_div_q, rx_div_d;
    logic [DIV_W-1:0]     rx_baud_q, rx_baud_d;
    logic [OS_W-1:0]      rx_os_q, rx_os_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_en_q, rx_par_en_d;
    logic                 rx_par_odd_q, rx_par_odd_d;
    logic                 rx_pend_q, rx_pend_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_tick, rx_fall, rx_mid, rx_sample;

    assign rx_tick   = (rx_div_q == '0);
    assign rx_fall   = rx_prev_q && !rx_sync_q;
    assign rx_mid    = rx_tick && (rx_os_q == OS_HALF);
    assign rx_sample = rx_tick && (rx_os_q == OS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_div_q     <= '0;
            rx_baud_q    <= '0;
            rx_os_q      <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_pend_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_div_q     <= rx_div_d;
            rx_baud_q    <= rx_baud_d;
            rx_os_q      <= rx_os_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_pend_q    <= rx_pend_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_div_d     = rx_div_q;
        rx_baud_d    = rx_baud_q;
        rx_os_d      = rx_os_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_pend_d    = rx_pend_q;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        rx_perr_d    = rx_perr_q;
        rx_ferr_d    = rx_ferr_q;

        if (rx_state_q != RX_IDLE) begin
            if (rx_tick) begin
                rx_div_d = rx_baud_q;
                rx_os_d  = rx_sample ? '0 : rx_os_q + 1'b1;
            end else begin
                rx_div_d = rx_div_q - 1'b1;
            end
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d   = RX_START;
                    rx_baud_d    = baud_div;
                    rx_div_d     = baud_div;
                    rx_par_en_d  = par_en_in;
                    rx_par_odd_d = (parity_mode == 2'd2);
                    rx_os_d      = '0;
                    rx_bit_d     = '0;
                    rx_pend_d    = 1'b0;
                end
            end
            RX_START: begin
                // Half-bit sample; a line already back high was only a glitch.
                if (rx_mid) begin
                    rx_os_d    = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_pend_d  = rx_sync_q ^ (^rx_shift_q) ^ rx_par_odd_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = rx_pend_q;
                    rx_ferr_d  = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_busy       = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: frame-level reference model of the serial
// line, randomized frames, loopback and directly driven receive scenarios.
module tb_uart_cfg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 4;
    localparam int DIV_W      = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DIV_W-1:0]     baud_div;
    logic [1:0]           parity_mode;
    logic                 two_stop;
    logic                 rx;
    logic                 tx;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_busy;

    logic loop_en;
    logic rx_drive;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rx_ev_t;

    rx_ev_t rx_q[$];
    logic   exp_bits[$];

    assign rx = loop_en ? tx : rx_drive;

    always #5 clk = ~clk;

    uart_cfg #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .DIV_W     (DIV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_div     (baud_div),
        .parity_mode  (parity_mode),
        .two_stop     (two_stop),
        .rx           (rx),
        .tx           (tx),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    // Every completed receive frame is logged for the scenario tasks to inspect.
    always @(negedge clk) begin
        rx_ev_t ev;
        if (!rst && rx_valid === 1'b1) begin
            ev.d  = rx_data;
            ev.pe = rx_parity_err;
            ev.fe = rx_frame_err;
            rx_q.push_back(ev);
        end
    end

    // Serial line levels of one frame, one entry per bit period.
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] m, input logic ts);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (m == 2'd1)      exp_bits.push_back(^d);
        else if (m == 2'd2) exp_bits.push_back(~^d);
        exp_bits.push_back(1'b1);
        if (ts) exp_bits.push_back(1'b1);
    endfunction

    function automatic logic exp_perr(input logic [7:0] d, input logic [1:0] mtx, input logic [1:0] mrx);
        logic sent, want;
        if (mrx != 2'd1 && mrx != 2'd2) return 1'b0;
        sent = (mtx == 2'd2) ? ~^d : ^d;
        want = (mrx == 2'd2) ? ~^d : ^d;
        return sent != want;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic [1:0] mtx, input logic [1:0] mrx,
                             input logic ts, input logic [15:0] b);
        int t = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        baud_div    = b;
        parity_mode = mtx;
        two_stop    = ts;
        tx_data     = d;
        tx_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid    = 1'b0;
        parity_mode = mrx;
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop_level, input logic [15:0] b);
        int len;
        len = OVERSAMPLE * (int'(b) + 1);
        @(negedge clk);
        baud_div = b;
        rx_drive = 1'b0;
        repeat (len) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drive = d[i];
            repeat (len) @(negedge clk);
        end
        rx_drive = stop_level;
        repeat (len) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)        begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
        checks++; if (tx_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_tx_ready: got %b want 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00)  begin errors++; $display("[TB] FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_parity_err !== 1'b0 || rx_frame_err !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_flags: got pe=%b fe=%b want 0 0", rx_parity_err, rx_frame_err); end
        checks++; if (rx_busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset_rx_busy: got %b want 0", rx_busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1 || tx_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL post_reset_idle: got tx=%b ready=%b want 1 1", tx, tx_ready); end
    endtask

    task automatic test_tx_frames();
        logic [7:0]  d;
        logic [1:0]  m;
        logic        ts;
        logic [15:0] b;
        logic        seen;
        int          len, ready_low, bad;
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        rx_q.delete();
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin
                d = 8'hA5; m = 2'd0; ts = 1'b0; b = 16'd3;
            end else begin
                d  = 8'($urandom_range(0, 255));
                m  = 2'($urandom_range(0, 3));
                ts = 1'($urandom_range(0, 1));
                b  = 16'($urandom_range(0, 3));
            end
            build_frame(d, m, ts);
            len = OVERSAMPLE * (int'(b) + 1);
            @(negedge clk);
            baud_div = b; parity_mode = m; two_stop = ts; tx_data = d; tx_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            // Config changes after the handshake must not disturb the frame in flight.
            tx_valid    = 1'b0;
            baud_div    = 16'($urandom_range(0, 7));
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
            tx_data     = 8'($urandom_range(0, 255));
            ready_low   = 0;
            for (int i = 0; i < exp_bits.size(); i++) begin
                seen = exp_bits[i];
                bad  = 0;
                for (int c = 0; c < len; c++) begin
                    if (tx !== exp_bits[i]) begin bad++; seen = tx; end
                    if (tx_ready !== 1'b1) ready_low++;
                    @(negedge clk);
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("[TB] FAIL tx_bit frame=%0d bit=%0d data=%h: tx=%b on %0d of %0d clocks, want %b",
                             n, i, d, seen, bad, len, exp_bits[i]);
                end
            end
            checks++;
            if (ready_low != exp_bits.size() * len) begin
                errors++;
                $display("[TB] FAIL tx_ready_low frame=%0d: got %0d cycles want %0d", n, ready_low, exp_bits.size() * len);
            end
            checks++;
            if (tx_ready !== 1'b1 || tx !== 1'b1) begin
                errors++;
                $display("[TB] FAIL tx_end frame=%0d: got tx=%b ready=%b want 1 1", n, tx, tx_ready);
            end
        end
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL tx_only_rx_quiet: got %0d rx frames want 0", rx_q.size()); end
    endtask

    task automatic test_glitch();
        int t = 0;
        loop_en = 1'b0; rx_drive = 1'b1; baud_div = 16'd3; parity_mode = 2'd0;
        rx_q.delete();
        @(negedge clk);
        rx_drive = 1'b0;
        repeat (4) @(negedge clk);
        rx_drive = 1'b1;
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_rise: got %b want 1", rx_busy); end
        while (rx_busy !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_fall: got %b want 0 within 200 clk", rx_busy); end
        repeat (100) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || rx_parity_err !== 1'b0 || rx_frame_err !== 1'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL glitch_quiet: got frames=%0d pe=%b fe=%b data=%h want 0 0 0 00",
                     rx_q.size(), rx_parity_err, rx_frame_err, rx_data);
        end
    endtask

    task automatic test_loopback_random();
        logic [7:0]  d;
        logic [1:0]  m;
        logic        ts;
        logic [15:0] b;
        rx_ev_t      ev;
        int          t;
        loop_en = 1'b1;
        rx_q.delete();
        for (int n = 0; n < 6; n++) begin
            d  = 8'($urandom_range(0, 255));
            m  = 2'($urandom_range(0, 3));
            ts = 1'($urandom_range(0, 1));
            b  = 16'($urandom_range(0, 3));
            send_byte(d, m, m, ts, b);
            t = 0;
            while (rx_q.size() < 1 && t < 3000) begin @(negedge clk); t++; end
            checks++;
            if (rx_q.size() != 1) begin
                errors++;
                $display("[TB] FAIL loop_count n=%0d: got %0d frames want 1", n, rx_q.size());
                rx_q.delete();
            end else begin
                ev = rx_q.pop_front();
                checks++;
                if (ev.d !== d || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL loop_frame n=%0d mode=%0d: got data=%h pe=%b fe=%b want %h 0 0",
                             n, m, ev.d, ev.pe, ev.fe, d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rx_ev_t ev;
        int     cnt = 0;
        int     t = 0;
        loop_en = 1'b1;
        rx_q.delete();
        @(negedge clk);
        while (tx_ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        baud_div = 16'd3; parity_mode = 2'd1; two_stop = 1'b0; tx_data = 8'h3C; tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h81;
        while (tx_ready !== 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
        checks++;
        if (cnt != 11 * 16) begin errors++; $display("[TB] FAIL b2b_ready_low: got %0d cycles want %0d", cnt, 11 * 16); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("[TB] FAIL b2b_handshake_level: got tx=%b want 1", tx); end
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (tx !== 1'b0 || tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second_start: got tx=%b ready=%b want 0 0", tx, tx_ready);
        end
        t = 0;
        while (rx_q.size() < 2 && t < 3000) begin @(negedge clk); t++; end
        checks++;
        if (rx_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d frames want 2", rx_q.size());
        end else begin
            ev = rx_q.pop_front();
            checks++;
            if (ev.d !== 8'h3C || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
                errors++; $display("[TB] FAIL b2b_first: got data=%h pe=%b fe=%b want 3c 0 0", ev.d, ev.pe, ev.fe);
            end
            ev = rx_q.pop_front();
            checks++;
            if (ev.d !== 8'h81 || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
                errors++; $display("[TB] FAIL b2b_second: got data=%h pe=%b fe=%b want 81 0 0", ev.d, ev.pe, ev.fe);
            end
        end
    endtask

    task automatic test_parity_mismatch();
        logic [7:0] d;
        logic [1:0] mtx, mrx;
        rx_ev_t     ev;
        int         t;
        loop_en = 1'b1;
        rx_q.delete();
        for (int n = 0; n < 3; n++) begin
            if (n == 0) begin
                d = 8'h07; mtx = 2'd2; mrx = 2'd1;
            end else begin
                d   = 8'($urandom_range(0, 255));
                mtx = 2'($urandom_range(1, 2));
                mrx = 2'd3 - mtx;
            end
            send_byte(d, mtx, mrx, 1'b0, 16'd3);
            t = 0;
            while (rx_q.size() < 1 && t < 3000) begin @(negedge clk); t++; end
            checks++;
            if (rx_q.size() != 1) begin
                errors++;
                $display("[TB] FAIL parity_count n=%0d: got %0d frames want 1", n, rx_q.size());
                rx_q.delete();
            end else begin
                ev = rx_q.pop_front();
                checks++;
                if (ev.d !== d || ev.pe !== exp_perr(d, mtx, mrx) || ev.fe !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL parity_frame n=%0d: got data=%h pe=%b fe=%b want %h %b 0",
                             n, ev.d, ev.pe, ev.fe, d, exp_perr(d, mtx, mrx));
                end
            end
        end
    endtask

    task automatic test_frame_err();
        rx_ev_t ev;
        loop_en = 1'b0; rx_drive = 1'b1; parity_mode = 2'd0;
        rx_q.delete();
        drive_rx(8'h55, 1'b0, 16'd3);
        rx_drive = 1'b0;
        repeat (32) @(negedge clk);
        rx_drive = 1'b1;
        repeat (32) @(negedge clk);
        drive_rx(8'h12, 1'b1, 16'd3);
        rx_drive = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (rx_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL frame_err_count: got %0d frames want 2", rx_q.size());
        end else begin
            ev = rx_q.pop_front();
            checks++;
            if (ev.d !== 8'h55 || ev.pe !== 1'b0 || ev.fe !== 1'b1) begin
                errors++; $display("[TB] FAIL frame_err_bad: got data=%h pe=%b fe=%b want 55 0 1", ev.d, ev.pe, ev.fe);
            end
            ev = rx_q.pop_front();
            checks++;
            if (ev.d !== 8'h12 || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
                errors++; $display("[TB] FAIL frame_err_recover: got data=%h pe=%b fe=%b want 12 0 0", ev.d, ev.pe, ev.fe);
            end
        end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_err_idle: got busy=%b want 0", rx_busy); end
    endtask

    task automatic test_reset_mid();
        rx_ev_t ev;
        int     t = 0;
        loop_en = 1'b1;
        rx_q.delete();
        send_byte(8'hC3, 2'd0, 2'd0, 1'b0, 16'd3);
        repeat (3 * 16 + 5) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1 || tx_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_frame_active: got busy=%b ready=%b want 1 0", rx_busy, tx_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL async_reset_tx: got tx=%b ready=%b want 1 1", tx, tx_ready);
        end
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++; $display("[TB] FAIL async_reset_rx: got busy=%b valid=%b data=%h want 0 0 00", rx_busy, rx_valid, rx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL aborted_frame_quiet: got %0d frames want 0", rx_q.size()); end
        rx_q.delete();
        send_byte(8'hFF, 2'd0, 2'd0, 1'b0, 16'd3);
        while (rx_q.size() < 1 && t < 3000) begin @(negedge clk); t++; end
        checks++;
        if (rx_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL after_reset_count: got %0d frames want 1", rx_q.size());
        end else begin
            ev = rx_q.pop_front();
            checks++;
            if (ev.d !== 8'hFF || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
                errors++; $display("[TB] FAIL after_reset_frame: got data=%h pe=%b fe=%b want ff 0 0", ev.d, ev.pe, ev.fe);
            end
        end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        baud_div    = 16'd3;
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        loop_en     = 1'b0;
        rx_drive    = 1'b1;

        test_reset();
        test_tx_frames();
        test_glitch();
        test_loopback_random();
        test_back_to_back();
        test_parity_mismatch();
        test_frame_err();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
